mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports, the shared data-memory port and the
// arbiter status signals; the arbiter uses the slave view, the driver the master view.
interface mem_port_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          m0_req;
    logic          m0_wmem;
    logic          m0_memc;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_wmem;
    logic          m1_memc;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic          mem_wmem;
    logic          mem_memc;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          busy;
    logic [1:0]    owner;

    modport slave (
        input  m0_req, m0_wmem, m0_memc, m0_addr, m0_wdata,
        input  m1_req, m1_wmem, m1_memc, m1_addr, m1_wdata,
        input  mem_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output mem_wmem, mem_memc, mem_addr, mem_wdata,
        output busy, owner
    );

    modport master (
        output m0_req, m0_wmem, m0_memc, m0_addr, m0_wdata,
        output m1_req, m1_wmem, m1_memc, m1_addr, m1_wdata,
        output mem_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  mem_wmem, mem_memc, mem_addr, mem_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory:
// IDLE picks an owner, ACC drives the memory for one cycle, RESP pulses the owner's ack.
module mem_port_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ACC  = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_M0   = 2'b01;
    localparam logic [1:0] OWN_M1   = 2'b10;

    state_t        state_r;
    state_t        state_s;
    logic [1:0]    owner_r;
    logic [1:0]    owner_s;
    logic [1:0]    grant_s;
    logic          last_owner_r;
    logic          last_owner_s;
    logic          busy_r;
    logic          m0_ack_r;
    logic          m1_ack_r;
    logic [DW-1:0] m0_rdata_r;
    logic [DW-1:0] m1_rdata_r;
    logic          acc_m0_s;
    logic          acc_m1_s;

    logic          mem_wmem_s;
    logic          mem_memc_s;
    logic [AW-1:0] mem_addr_s;
    logic [DW-1:0] mem_wdata_s;

    // last_owner holds the index of the requester served most recently;
    // on a tie the other one wins.
    function automatic logic [1:0] arb_pick(input logic req0, input logic req1,
                                            input logic last_owner);
        logic [1:0] pick;
        case ({req1, req0})
            2'b01:   pick = OWN_M0;
            2'b10:   pick = OWN_M1;
            2'b11:   pick = last_owner ? OWN_M0 : OWN_M1;
            default: pick = OWN_NONE;
        endcase
        return pick;
    endfunction

    assign grant_s  = arb_pick(bus.m0_req, bus.m1_req, last_owner_r);
    assign acc_m0_s = (state_r == ST_ACC) && (owner_r == OWN_M0);
    assign acc_m1_s = (state_r == ST_ACC) && (owner_r == OWN_M1);

    // Next-state, next-owner and round-robin pointer update.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s != OWN_NONE) begin
                    state_s = ST_ACC;
                    owner_s = grant_s;
                end else begin
                    state_s = ST_IDLE;
                    owner_s = OWN_NONE;
                end
            end
            ST_ACC: begin
                state_s = ST_RESP;
            end
            ST_RESP: begin
                state_s      = ST_IDLE;
                owner_s      = OWN_NONE;
                last_owner_s = (owner_r == OWN_M1);
            end
            default: begin
                state_s = ST_IDLE;
                owner_s = OWN_NONE;
            end
        endcase
    end

    // Memory port mux: only the owner's fields, and only during ACC.
    always_comb begin
        mem_wmem_s  = 1'b0;
        mem_memc_s  = 1'b0;
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {DW{1'b0}};
        if (acc_m1_s) begin
            mem_wmem_s  = bus.m1_wmem;
            mem_memc_s  = bus.m1_memc;
            mem_addr_s  = bus.m1_addr;
            mem_wdata_s = bus.m1_wdata;
        end else if (acc_m0_s) begin
            mem_wmem_s  = bus.m0_wmem;
            mem_memc_s  = bus.m0_memc;
            mem_addr_s  = bus.m0_addr;
            mem_wdata_s = bus.m0_wdata;
        end else begin
            mem_wmem_s  = 1'b0;
            mem_memc_s  = 1'b0;
            mem_addr_s  = {AW{1'b0}};
            mem_wdata_s = {DW{1'b0}};
        end
    end

    // FSM state, owner, round-robin pointer and busy flag.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_NONE;
            last_owner_r <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            busy_r       <= (state_s != ST_IDLE);
        end
    end

    // Completion pulses: the ACC-ending edge raises the owner's ack for the RESP cycle.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            m0_ack_r <= 1'b0;
            m1_ack_r <= 1'b0;
        end else begin
            m0_ack_r <= acc_m0_s;
            m1_ack_r <= acc_m1_s;
        end
    end

    // Read-data capture; writes also capture, so the owner always sees the memory word.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            m0_rdata_r <= {DW{1'b0}};
            m1_rdata_r <= {DW{1'b0}};
        end else begin
            if (acc_m0_s) begin
                m0_rdata_r <= bus.mem_rdata;
            end
            if (acc_m1_s) begin
                m1_rdata_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.m0_ack    = m0_ack_r;
    assign bus.m1_ack    = m1_ack_r;
    assign bus.m0_rdata  = m0_rdata_r;
    assign bus.m1_rdata  = m1_rdata_r;
    assign bus.mem_wmem  = mem_wmem_s;
    assign bus.mem_memc  = mem_memc_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.busy      = busy_r;
    assign bus.owner     = owner_r;

endmodule
